ds18b20_seq: RTL



---
 rtl/ow_pkg.sv | 46 ++++
 rtl/crc8_maxim.sv | 28 ++
 rtl/ds18b20_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ow_pkg.sv
// Shared 1-Wire definitions: ROM/function commands, CRC polynomial and
// the DS18B20 sequencer state/step encodings.
package ow_pkg;

  localparam logic [7:0] OW_SKIP_ROM  = 8'hCC;
  localparam logic [7:0] OW_CONVERT_T = 8'h44;
  localparam logic [7:0] OW_READ_SP   = 8'hBE;
  localparam logic [7:0] OW_CRC_POLY  = 8'h8C;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_CWAIT,
    S_CRC,
    S_CHECK,
    S_FINISH
  } seq_state_t;

  typedef enum logic [2:0] {
    ST_RST1,
    ST_SKIP1,
    ST_CONV,
    ST_RST2,
    ST_SKIP2,
    ST_RDSP,
    ST_RD8,
    ST_RD1
  } seq_step_t;

  function automatic seq_step_t next_step(input seq_step_t s);
    case (s)
      ST_RST1:  return ST_SKIP1;
      ST_SKIP1: return ST_CONV;
      ST_CONV:  return ST_RST2;
      ST_RST2:  return ST_SKIP2;
      ST_SKIP2: return ST_RDSP;
      ST_RDSP:  return ST_RD8;
      ST_RD8:   return ST_RD1;
      default:  return ST_RST1;
    endcase
  endfunction

endpackage

// File: rtl/crc8_maxim.sv
// Bit-serial Dallas/Maxim CRC-8 (reflected poly 0x8C, init 0x00).
// Feed data LSB first; clear has priority over bit_valid.
module crc8_maxim
  import ow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[0] ^ bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (bit_valid) begin
      crc <= {1'b0, crc[7:1]} ^ (fb ? OW_CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/ds18b20_seq.sv
// Autonomous DS18B20 acquisition sequencer driving the one_wire byte engine:
// convert, wait, read scratchpad, CRC check, deliver raw temperature.
module ds18b20_seq
  import ow_pkg::*;
#(
  parameter int unsigned CONV_CYCLES    = 36000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ow_reset,
  output logic        ow_write,
  output logic        ow_read,
  output logic [7:0]  ow_in_byte,
  output logic [5:0]  ow_start_bit,
  output logic [5:0]  ow_end_bit,
  input  logic        ow_busy,
  input  logic        ow_presence,
  input  logic [63:0] ow_out_byte,
  output logic        busy,
  output logic        done,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        no_device,
  output logic        crc_err,
  output logic        timeout
);

  localparam logic [31:0] OP_LIMIT   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] CONV_LIMIT = 32'(CONV_CYCLES - 1);

  seq_state_t  state;
  seq_step_t   step;
  logic [31:0] op_timer;
  logic [31:0] cw_cnt;
  logic        presence;
  logic [63:0] sp;
  logic [7:0]  crc_rx;
  logic [5:0]  bit_idx;
  logic [7:0]  crc;
  logic        crc_clear;
  logic        crc_bit_valid;
  logic        crc_bit_in;

  assign crc_clear     = (state == S_IDLE);
  assign crc_bit_valid = (state == S_CRC);
  assign crc_bit_in    = sp[bit_idx];

  crc8_maxim u_crc (
    .clk       (clk),
    .rst       (rst),
    .clear     (crc_clear),
    .bit_valid (crc_bit_valid),
    .bit_in    (crc_bit_in),
    .crc       (crc)
  );

  // LOAD registers the strobe and operands, so each strobe is high exactly
  // for the single ISSUE cycle that follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      step         <= ST_RST1;
      op_timer     <= '0;
      cw_cnt       <= '0;
      presence     <= 1'b0;
      sp           <= '0;
      crc_rx       <= '0;
      bit_idx      <= '0;
      ow_reset     <= 1'b0;
      ow_write     <= 1'b0;
      ow_read      <= 1'b0;
      ow_in_byte   <= '0;
      ow_start_bit <= '0;
      ow_end_bit   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      temp         <= '0;
      temp_valid   <= 1'b0;
      no_device    <= 1'b0;
      crc_err      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      ow_reset   <= 1'b0;
      ow_write   <= 1'b0;
      ow_read    <= 1'b0;
      done       <= 1'b0;
      temp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            no_device <= 1'b0;
            crc_err   <= 1'b0;
            timeout   <= 1'b0;
            step      <= ST_RST1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          op_timer <= '0;
          presence <= 1'b0;
          state    <= S_ISSUE;
          case (step)
            ST_RST1, ST_RST2: ow_reset <= 1'b1;
            ST_SKIP1, ST_SKIP2: begin
              ow_write     <= 1'b1;
              ow_in_byte   <= OW_SKIP_ROM;
              ow_start_bit <= 6'd0;
              ow_end_bit   <= 6'd7;
            end
            ST_CONV: begin
              ow_write     <= 1'b1;
              ow_in_byte   <= OW_CONVERT_T;
              ow_start_bit <= 6'd0;
              ow_end_bit   <= 6'd7;
            end
            ST_RDSP: begin
              ow_write     <= 1'b1;
              ow_in_byte   <= OW_READ_SP;
              ow_start_bit <= 6'd0;
              ow_end_bit   <= 6'd7;
            end
            ST_RD8: begin
              ow_read      <= 1'b1;
              ow_start_bit <= 6'd0;
              ow_end_bit   <= 6'd63;
            end
            default: begin
              ow_read      <= 1'b1;
              ow_start_bit <= 6'd56;
              ow_end_bit   <= 6'd63;
            end
          endcase
        end

        S_ISSUE: begin
          op_timer <= op_timer + 32'd1;
          state    <= S_WAIT_HI;
        end

        S_WAIT_HI: begin
          op_timer <= op_timer + 32'd1;
          if (ow_busy) begin
            state <= S_WAIT_LO;
          end else if (op_timer >= OP_LIMIT) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= S_FINISH;
          end
        end

        S_WAIT_LO: begin
          op_timer <= op_timer + 32'd1;
          if (ow_presence) presence <= 1'b1;
          if (!ow_busy) begin
            case (step)
              ST_RST1, ST_RST2: begin
                if (!(presence || ow_presence)) begin
                  no_device <= 1'b1;
                  done      <= 1'b1;
                  state     <= S_FINISH;
                end else begin
                  step  <= next_step(step);
                  state <= S_LOAD;
                end
              end
              ST_CONV: begin
                cw_cnt <= '0;
                step   <= ST_RST2;
                state  <= S_CWAIT;
              end
              ST_RD8: begin
                sp    <= ow_out_byte;
                step  <= ST_RD1;
                state <= S_LOAD;
              end
              ST_RD1: begin
                crc_rx  <= ow_out_byte[63:56];
                bit_idx <= '0;
                state   <= S_CRC;
              end
              default: begin
                step  <= next_step(step);
                state <= S_LOAD;
              end
            endcase
          end else if (op_timer >= OP_LIMIT) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= S_FINISH;
          end
        end

        S_CWAIT: begin
          if (cw_cnt == CONV_LIMIT) begin
            state <= S_LOAD;
          end else begin
            cw_cnt <= cw_cnt + 32'd1;
          end
        end

        S_CRC: begin
          bit_idx <= bit_idx + 6'd1;
          if (bit_idx == 6'd63) state <= S_CHECK;
        end

        S_CHECK: begin
          done  <= 1'b1;
          state <= S_FINISH;
          if (crc == crc_rx) begin
            temp       <= sp[15:0];
            temp_valid <= 1'b1;
          end else begin
            crc_err <= 1'b1;
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
